// File: rtl/result_row_streamer_if.sv
// Matrix-in / row-out bus of the result row streamer.
// The master modport is the streamer's own view; slave is the environment's.
interface result_row_streamer_if #(
  parameter int N            = 3,
  parameter int OUTPUT_WIDTH = 16
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [0:N-1][0:N-1][OUTPUT_WIDTH-1:0] mat_in;
  logic                                  mat_valid_in;
  logic [0:N-1][OUTPUT_WIDTH-1:0]        row_out;
  logic                                  row_valid;
  logic                                  row_ready;
  logic [IDX_W-1:0]                      row_idx;
  logic                                  row_last;

  modport master (
    input  mat_in, mat_valid_in, row_ready,
    output row_out, row_valid, row_idx, row_last
  );

  modport slave (
    output mat_in, mat_valid_in, row_ready,
    input  row_out, row_valid, row_idx, row_last
  );
endinterface

// File: rtl/result_row_streamer.sv
// Streams an assembled NxN result matrix out one row per handshake, with a
// one-deep pending buffer so back-to-back matrices leave without a bubble.
module result_row_streamer #(
  parameter int N            = 3,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  result_row_streamer_if.master        bus,
  output logic                         busy,
  output logic                         overflow
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, STREAM} state_t;
  typedef logic [0:N-1][0:N-1][OUTPUT_WIDTH-1:0] mat_t;

  state_t           state_q, state_d;
  mat_t             active_q, active_d;
  mat_t             pending_q, pending_d;
  logic             active_full_q, active_full_d;
  logic             pending_full_q, pending_full_d;
  logic             overflow_q, overflow_d;
  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic             mat_valid_q;
  logic             armed_q;

  logic capture;
  logic transfer;
  logic at_last;

  // armed_q blocks a level still high across reset release from looking like
  // a fresh rising edge; it arms once mat_valid_in has been seen low.
  assign capture  = bus.mat_valid_in && !mat_valid_q && armed_q;
  assign transfer = (state_q == STREAM) && bus.row_ready;
  assign at_last  = (row_idx_q == IDX_W'(N - 1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d        = state_q;
    active_d       = active_q;
    pending_d      = pending_q;
    active_full_d  = active_full_q;
    pending_full_d = pending_full_q;
    overflow_d     = overflow_q;
    row_idx_d      = row_idx_q;

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          active_d      = bus.mat_in;
          active_full_d = 1'b1;
          row_idx_d     = '0;
          state_d       = STREAM;
        end
      end

      STREAM: begin
        logic direct_load;
        direct_load = 1'b0;

        if (transfer) begin
          if (!at_last) begin
            row_idx_d = row_idx_q + IDX_W'(1);
          end else if (pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
            row_idx_d      = '0;
          end else if (capture) begin
            active_d    = bus.mat_in;
            row_idx_d   = '0;
            direct_load = 1'b1;
          end else begin
            state_d       = IDLE;
            active_full_d = 1'b0;
            row_idx_d     = '0;
          end
        end

        // The drop decision looks at pending_full_q, i.e. before any same-cycle free.
        if (capture && !direct_load) begin
          if (!pending_full_q) begin
            pending_d      = bus.mat_in;
            pending_full_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the matrix buffers are reset to zero too, so no stale data survives a reset.
      state_q        <= IDLE;
      active_q       <= '0;
      pending_q      <= '0;
      active_full_q  <= 1'b0;
      pending_full_q <= 1'b0;
      overflow_q     <= 1'b0;
      row_idx_q      <= '0;
      mat_valid_q    <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
      state_q        <= state_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      active_full_q  <= active_full_d;
      pending_full_q <= pending_full_d;
      overflow_q     <= overflow_d;
      row_idx_q      <= row_idx_d;
      mat_valid_q    <= bus.mat_valid_in;
      armed_q        <= armed_q | !bus.mat_valid_in;
    end
  end

  assign bus.row_valid = (state_q == STREAM);
  assign bus.row_idx   = row_idx_q;
  assign bus.row_last  = (state_q == STREAM) && at_last;
  assign bus.row_out   = active_q[row_idx_q];
  assign busy          = active_full_q || pending_full_q;
  assign overflow      = overflow_q;
endmodule

// File: doc/result_row_streamer.md
RESULT_ROW_STREAMER -- requirements
Module: result_row_streamer

Interface
REQ-001 Parameters SHALL be: N, default 3, systolic array dimension (N >= 2); OUTPUT_WIDTH, default 16, element width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; reset is synchronous and active-high.
REQ-004 mat_in  input  OUTPUT_WIDTH x [0:N-1][0:N-1]  assembled result matrix from the output collection stage, [row][col].
REQ-005 mat_valid_in  input  1  matrix-complete flag from the collection stage; may stay high indefinitely once set.
REQ-006 row_out  output  OUTPUT_WIDTH x [0:N-1]  current row, element [c] = matrix[row_idx][c].
REQ-007 row_valid  output  1  row_out, row_idx and row_last are valid.
REQ-008 row_ready  input  1  downstream accepts the row.
REQ-009 row_idx  output  $clog2(N)  index of the row on row_out.
REQ-010 row_last  output  1  high when row_idx == N-1 and row_valid is high.
REQ-011 busy  output  1  high when the active buffer or the pending buffer holds a matrix.
REQ-012 overflow  output  1  sticky flag: a matrix was dropped.

Function
REQ-013 A capture event SHALL be a rising edge of mat_valid_in: high this cycle, low the previous cycle. The previous-cycle register reads 0 after reset.
REQ-014 Storage SHALL be two NxN buffers, ACTIVE (streaming) and PENDING (one-deep queue), each with its own full flag.
REQ-015 The FSM SHALL have exactly two states, IDLE and STREAM. row_valid SHALL be 1 exactly when the state is STREAM.
REQ-016 IDLE with a capture event: mat_in SHALL be copied to ACTIVE, row_idx set to 0, and the FSM SHALL enter STREAM. row_valid rises on the next cycle, giving a latency of 1 cycle.
REQ-017 A transfer SHALL occur in a cycle when row_valid && row_ready.
REQ-018 Without a transfer, row_out, row_idx and row_last SHALL hold stable.
REQ-019 A transfer with row_idx < N-1 SHALL increment row_idx by 1, with no bubble between rows.
REQ-020 A transfer with row_idx == N-1 and PENDING full: PENDING SHALL move to ACTIVE, row_idx SHALL go to 0, and the FSM SHALL stay in STREAM. Row 0 of the new matrix is presented on the next cycle with no bubble.
REQ-021 A transfer with row_idx == N-1, PENDING empty and a simultaneous capture event: mat_in SHALL go directly into ACTIVE, row_idx SHALL go to 0, and the FSM SHALL stay in STREAM.
REQ-022 A transfer with row_idx == N-1, PENDING empty and no capture event: the FSM SHALL return to IDLE and ACTIVE SHALL be marked empty.
REQ-023 STREAM with a capture event, excluding the REQ-021 case: mat_in SHALL go to PENDING if PENDING is empty.
REQ-024 If PENDING is full in the REQ-023 case, the matrix SHALL be dropped and overflow SHALL be set. This holds even if PENDING is freed in the same cycle: the drop decision uses pre-edge state.
REQ-025 overflow SHALL clear only on reset.
REQ-026 row_out SHALL be driven combinationally from ACTIVE indexed by registered row_idx; no other combinational path from inputs to outputs is permitted.
REQ-027 Element values SHALL pass bit-exact, with no arithmetic, sign change or truncation.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL set: FSM to IDLE; both buffers to empty and zeroed; row_idx = 0; row_valid = 0; row_last = 0; busy = 0; overflow = 0; previous-cycle mat_valid_in register = 0.
REQ-029 Reset asserted mid-stream SHALL abort the current matrix and the pending matrix with no further rows emitted.
REQ-030 After reset release, a mat_valid_in that is still high SHALL NOT count as a capture event until it has been low for at least one cycle.
REQ-031 Capture events and handshakes SHALL be ignored in any cycle where rst is high.

Verification
REQ-032 N=3, mat_in[r][c]=10r+c, single pulse of mat_valid_in, row_ready tied 1 -> rows {0,1,2},{10,11,12},{20,21,22} on 3 consecutive cycles starting 1 cycle after the capture; row_last high only on the third; busy = 0 after.
REQ-033 Same matrix, row_ready low for 4 cycles at row 1 -> row_out = {10,11,12} and row_idx = 1 held for all 4 cycles; no row skipped or duplicated.
REQ-034 Second capture (values +100) during row 0 of the first, row_ready tied 1 -> 6 rows back-to-back with no bubble; the 4th row is {100,101,102} with row_idx = 0.
REQ-035 Third capture while ACTIVE and PENDING are full -> overflow = 1 and stays 1; the third matrix is never emitted; the first two are emitted intact.
REQ-036 mat_valid_in held high continuously for 20 cycles -> exactly one matrix captured. Then rst pulsed at row 1 with mat_valid_in still high -> row_valid = 0 the next cycle and no capture until mat_valid_in toggles low then high.
